// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding and frame data width,
// common to the rx and tx paths.
`default_nettype none

package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int UART_DATA_BITS = 8;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags
// and an occupancy count wide enough to tell full from empty.
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam logic [c_aw:0] c_full_count = (c_aw + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]  r_wr_ptr;
   logic [c_aw-1:0]  r_rd_ptr;
   logic [c_aw:0]    r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_push;
   logic             w_pop;
   logic [c_aw:0]    w_count_next;

   assign w_push = push && !r_full;
   assign w_pop  = pop && !r_empty;

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // Flags are registered from the next count so the ready output is a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
         r_full  <= (w_count_next == c_full_count);
         r_empty <= (w_count_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = r_full;
   assign empty = r_empty;
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_buffered_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, FIFO queue,
// bit-timed serializer driving an idle-high txd line.
`default_nettype none

module uart_buffered_tx
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 85,
   parameter int FIFO_DEPTH       = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int c_bit_cycles = 2 * CLK_PER_HALF_BIT;
   localparam int c_tw         = $clog2(c_bit_cycles);
   localparam logic [c_tw-1:0] c_timer_last = c_tw'(c_bit_cycles - 1);
   localparam logic [2:0]      c_idx_last   = 3'(UART_DATA_BITS - 1);

   uart_state_t                 r_state;
   uart_state_t                 w_state_next;
   logic [c_tw-1:0]             r_timer;
   logic [2:0]                  r_idx;
   logic [UART_DATA_BITS-1:0]   r_shift;
   logic                        r_txd;
   logic                        r_busy;

   logic                        w_pop;
   logic                        w_bit_end;
   logic                        w_full;
   logic                        w_empty;
   logic [7:0]                  w_dout;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_valid),
      .pop   (w_pop),
      .din   (tx_data),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty),
      .count (fifo_count)
   );

   assign w_bit_end = (r_timer == c_timer_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = START;
            end
         end
         START: begin
            if (w_bit_end) w_state_next = DATA;
         end
         DATA: begin
            if (w_bit_end && (r_idx == c_idx_last)) w_state_next = STOP;
         end
         STOP: begin
            // Back-to-back frames: the next start bit follows the stop bit directly.
            if (w_bit_end) begin
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_state_next = START;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         if ((r_state == IDLE) || (w_state_next != r_state) || w_bit_end) begin
            r_timer <= '0;
         end else begin
            r_timer <= r_timer + 1'b1;
         end

         if (r_state != DATA) begin
            r_idx <= '0;
         end else if (w_bit_end) begin
            r_idx <= r_idx + 1'b1;
         end

         if (w_pop) begin
            r_shift <= w_dout;
         end else if ((r_state == DATA) && w_bit_end) begin
            r_shift <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
         end

         // Line level follows the state one clock later, keeping every level equally long.
         case (r_state)
            START:   r_txd <= 1'b0;
            DATA:    r_txd <= r_shift[0];
            default: r_txd <= 1'b1;
         endcase

         r_busy <= (r_state != IDLE) || !w_empty;
      end
   end

   assign tx_ready = !w_full;
   assign txd      = r_txd;
   assign busy     = r_busy;

endmodule

`default_nettype wire
